skew_feeder: RTL and testbench
==============================

SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 The block SHALL have parameter DW, default 64, total vector width in bits.
REQ-002 The block SHALL have parameter DN, default 8, lane count; lane width SDW = DW/DN = 8; the skew chain it feeds delays lane i by i cycles.
REQ-003 The block SHALL have parameter DEPTH, default 4, input FIFO depth in vectors (power of two, >= 2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream vector valid.
REQ-007 in_ready  output  1  FIFO can accept a vector.
REQ-008 in_data  input  DW  row vector, lane i at bits [8*i +: 8].
REQ-009 in_last  input  1  marks the final vector of a tile.
REQ-010 out_data  output  DW  registered vector to the skew chain.
REQ-011 out_valid  output  1  out_data carries a real vector (0 = bubble or flush).
REQ-012 out_flush  output  1  current output cycle is a tile-drain cycle.
REQ-013 tile_done  output  1  one-cycle pulse after the last flush cycle.

Function
REQ-014 Handshake: a vector and its in_last flag SHALL be pushed into the FIFO on a rising edge where in_valid=1 and in_ready=1; in_ready=1 iff FIFO occupancy < DEPTH; in_ready SHALL NOT depend combinationally on in_valid.
REQ-015 The FIFO SHALL use wrap-around read/write pointers modulo DEPTH plus an occupancy counter of log2(DEPTH)+1 bits; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-016 Full: no push occurs; in_ready=0, and the upstream holds in_valid and in_data.
REQ-017 Empty: no pop occurs; no bypass path from in_data to out_data.
REQ-018 The state machine SHALL have three states: IDLE, STREAM and FLUSH.
REQ-019 IDLE: on a cycle with FIFO non-empty, pop the head; out_data <= head, out_valid <= 1, out_flush <= 0.
REQ-019a IDLE transition: go to FLUSH if the popped head has last=1, else go to STREAM.
REQ-020 IDLE with FIFO empty: out_data <= 0, out_valid <= 0, out_flush <= 0.
REQ-021 STREAM: every cycle with FIFO non-empty, pop one vector, out_data <= head, out_valid <= 1.
REQ-021a STREAM: if the popped vector has last=1, load flush counter with DN-1 and go to FLUSH.
REQ-022 STREAM with FIFO empty: emit a bubble (out_data <= 0, out_valid <= 0) and stay in STREAM.
REQ-023 FLUSH: no pops; out_data <= 0, out_valid <= 0, out_flush <= 1 for exactly DN-1 consecutive cycles (7 at default), counted by a down-counter.
REQ-023a FLUSH exit: when the counter reaches 0, go to IDLE and assert tile_done for exactly the following cycle.
REQ-024 Pushes SHALL continue to be accepted during FLUSH; they are popped only after the return to IDLE.
REQ-025 Latency: a vector pushed at edge k into an empty FIFO, in IDLE or STREAM, SHALL appear on out_data with out_valid=1 after edge k+1.
REQ-026 Throughput: a continuous input stream SHALL sustain one vector per cycle with no bubbles.
REQ-027 Ordering: vectors SHALL leave the block in acceptance order, unmodified and lane-aligned (no skew applied here).
REQ-028 Simultaneous events: pushing a new tile's first vector on the final FLUSH cycle SHALL be legal; that vector is popped in IDLE no earlier than the cycle that tile_done is high.
REQ-029 A tile consisting of a single vector with in_last=1 SHALL produce 1 valid cycle, then DN-1 flush cycles, then the tile_done pulse.

Reset
REQ-030 While rst_n=0, and immediately on its falling edge: state=IDLE, FIFO pointers and occupancy=0, flush counter=0.
REQ-031 While rst_n=0, all outputs SHALL be 0: out_data, out_valid, out_flush, tile_done, in_ready.
REQ-032 After rst_n rises, in_ready SHALL be 1 from the first clock edge.
REQ-033 Reset asserted mid-tile or mid-FLUSH SHALL discard all buffered vectors, and no tile_done SHALL be produced for the aborted tile.

Verification
REQ-034 Single vector: push 0x0807060504030201 with in_last=1 into an empty FIFO.
REQ-034a Required response: out_data equals 0x0807060504030201 with out_valid=1 for 1 cycle, then 7 cycles with out_flush=1 and out_data=0, then tile_done=1 for 1 cycle.
REQ-035 Back-to-back: push 16 vectors (values 1..16, in_last on the 16th) on consecutive cycles.
REQ-035a Required response: 16 consecutive out_valid cycles in order 1..16, no bubbles, then 7 flush cycles.
REQ-036 Full FIFO: push 6 vectors while the state is held in FLUSH from a previous tile.
REQ-036a Required response: in_ready falls to 0 after the 4th accept, the 5th and 6th vectors are held, and all 6 vectors emerge in order after tile_done.
REQ-037 Gapped input: insert 2 idle cycles between vectors 3 and 4 of a 5-vector tile.
REQ-037a Required response: exactly 2 bubble cycles (out_valid=0, out_data=0, out_flush=0), then vectors 4 and 5, then the flush sequence.
REQ-038 Reset mid-FLUSH: assert rst_n=0 on the 3rd flush cycle with 2 vectors buffered.
REQ-038a Required response: all outputs 0 immediately, no tile_done, and after release the occupancy is 0 and in_ready=1.

Source files
------------

// File: rtl/skew_feeder_if.sv
// Handshake and output bus between an upstream row producer, the skew feeder
// and the downstream skew chain.
interface skew_feeder_if #(
    parameter int DW = 64
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_flush;
    logic          tile_done;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_data, out_valid, out_flush, tile_done
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_data, out_valid, out_flush, tile_done
    );
endinterface

// File: rtl/skew_feeder.sv
// Buffers row vectors in a small FIFO and feeds them, lane-aligned, to a skew
// chain; after each tile's last vector it emits DN-1 drain cycles and a done pulse.
module skew_feeder #(
    parameter int DW    = 64,
    parameter int DN    = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    skew_feeder_if.slave bus
);
    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = (DN > 2) ? $clog2(DN) : 1;
    localparam logic [AW:0]     DEPTH_C    = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0]   FLUSH_LOAD = CW'(DN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic          in_ready_q, in_ready_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_flush_q, out_flush_d;
    logic          tile_done_q, tile_done_d;
    logic          push_s, pop_s, empty_s, head_last_s;
    logic [DW-1:0] head_data_s;

    // in_ready is registered from next occupancy, so it never looks at in_valid
    assign push_s                     = bus.in_valid & in_ready_q;
    assign empty_s                    = (occ_q == '0);
    assign {head_last_s, head_data_s} = mem_q[rd_ptr_q];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flush = out_flush_q;
    assign bus.tile_done = tile_done_q;

    // FIFO storage; contents are don't-care until the occupancy covers them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.in_last, bus.in_data};
        end
    end

    // Occupancy update and the registered ready it drives
    always_comb begin
        occ_d = occ_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + (AW + 1)'(1);
            2'b01:   occ_d = occ_q - (AW + 1)'(1);
            default: occ_d = occ_q;
        endcase
        in_ready_d = (occ_d < DEPTH_C);
    end

    // Tile sequencer: pop in IDLE/STREAM, drain without popping in FLUSH
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop_s       = 1'b0;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_flush_d = 1'b0;
        tile_done_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    out_data_d  = head_data_s;
                    out_valid_d = 1'b1;
                    if (head_last_s) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_FLUSH: begin
                if (cnt_q != '0) begin
                    out_flush_d = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                end else begin
                    state_d     = ST_IDLE;
                    tile_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_flush_q <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_flush_q <= out_flush_d;
            tile_done_q <= tile_done_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_skew_feeder.sv
// Randomized and directed bench for skew_feeder; expectations come from a
// timing model that schedules each accepted vector's output edge arithmetically.
module tb_skew_feeder;
    localparam int DW    = 64;
    localparam int DN    = 8;
    localparam int DEPTH = 4;
    localparam int MAXE  = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    skew_feeder_if #(.DW(DW)) bus ();

    skew_feeder #(.DW(DW), .DN(DN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int full_seen;

    logic [DW-1:0] plan_data [$];
    bit            plan_last [$];
    int            plan_gap  [$];

    // expected output per edge: 0 bubble, 1 valid, 2 flush, 3 tile_done
    int            exp_kind [MAXE];
    int            exp_fnum [MAXE];
    logic [DW-1:0] exp_data [MAXE];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic add_vec(input logic [DW-1:0] d, input bit l, input int g);
        plan_data.push_back(d);
        plan_last.push_back(l);
        plan_gap.push_back(g);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        #1;
        check_val("rst_out_data", bus.out_data, 64'd0);
        check_val("rst_out_valid", bus.out_valid, 64'd0);
        check_val("rst_out_flush", bus.out_flush, 64'd0);
        check_val("rst_tile_done", bus.tile_done, 64'd0);
        check_val("rst_in_ready", bus.in_ready, 64'd0);
        repeat (cycles) begin
            @(negedge clk);
            check_val("rst_hold_done", bus.tile_done, 64'd0);
            check_val("rst_hold_valid", bus.out_valid, 64'd0);
        end
        rst_n = 1'b1;
    endtask

    // Drives the plan from a fresh reset and checks every cycle against the model.
    task automatic run_plan(input int abort_flush);
        int e = 0, idx = 0, gap_left = 0, acc = 0, pops = 0;
        int prev_t = 0, last_edge = 0, t;
        bit prev_last = 1'b0, accept, fin = 1'b0;
        for (int i = 0; i < MAXE; i++) begin
            exp_kind[i] = 0;
            exp_fnum[i] = 0;
            exp_data[i] = '0;
        end
        if (plan_data.size() > 0) gap_left = plan_gap[0];
        while (!fin) begin
            check_val("out_valid", bus.out_valid, 64'(exp_kind[e] == 1));
            check_val("out_flush", bus.out_flush, 64'(exp_kind[e] == 2));
            check_val("tile_done", bus.tile_done, 64'(exp_kind[e] == 3));
            check_val("out_data", bus.out_data, exp_data[e]);
            check_val("in_ready", bus.in_ready, 64'((e > 0) && ((acc - pops) < DEPTH)));
            if (e > 0 && !bus.in_ready) full_seen++;
            if (abort_flush > 0 && exp_kind[e] == 2 && exp_fnum[e] == abort_flush) begin
                fin = 1'b1;
            end else if (idx >= plan_data.size() && e > last_edge + 2) begin
                fin = 1'b1;
            end else if (e >= MAXE - 8) begin
                check_val("cycle_budget", 64'(e), 64'(MAXE - 8 - 1));
                fin = 1'b1;
            end else begin
                if (idx < plan_data.size() && gap_left == 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = plan_data[idx];
                    bus.in_last  = plan_last[idx];
                end else begin
                    if (gap_left > 0) gap_left--;
                    bus.in_valid = 1'b0;
                    bus.in_data  = {$urandom, $urandom};
                    bus.in_last  = 1'($urandom_range(0, 1));
                end
                accept = bus.in_valid && bus.in_ready;
                @(posedge clk);
                e++;
                if (accept) begin
                    t = e + 1;
                    if (prev_t + 1 + (prev_last ? DN : 0) > t) t = prev_t + 1 + (prev_last ? DN : 0);
                    if (t + DN >= MAXE) begin
                        check_val("sched_budget", 64'(t), 64'(MAXE - DN - 1));
                        fin = 1'b1;
                    end else begin
                        exp_kind[t] = 1;
                        exp_data[t] = plan_data[idx];
                        if (plan_last[idx]) begin
                            for (int k = 1; k < DN; k++) begin
                                exp_kind[t + k] = 2;
                                exp_fnum[t + k] = k;
                            end
                            exp_kind[t + DN] = 3;
                            last_edge = t + DN;
                        end else begin
                            last_edge = t;
                        end
                    end
                    prev_t    = t;
                    prev_last = plan_last[idx];
                    acc++;
                    idx++;
                    gap_left = (idx < plan_data.size()) ? plan_gap[idx] : 0;
                end
                if (exp_kind[e] == 1) pops++;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        plan_data.delete();
        plan_last.delete();
        plan_gap.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // single vector tile
        apply_reset(3);
        add_vec(64'h0807060504030201, 1'b1, 0);
        run_plan(0);

        // back-to-back 1..16
        apply_reset(2);
        for (int i = 1; i <= 16; i++) add_vec(64'(i), (i == 16), 0);
        run_plan(0);

        // FIFO fills while the previous tile drains
        apply_reset(2);
        full_seen = 0;
        add_vec(64'hA5A5_0000_0000_00A0, 1'b1, 0);
        for (int i = 1; i <= 6; i++) add_vec(64'hB000 + 64'(i), (i == 6), 0);
        run_plan(0);
        check_val("full_backpressure", 64'(full_seen > 0), 64'd1);

        // two idle cycles between vectors 3 and 4
        apply_reset(2);
        for (int i = 1; i <= 5; i++) add_vec(64'hC0 + 64'(i), (i == 5), (i == 4) ? 2 : 0);
        run_plan(0);

        // reset on the 3rd flush cycle with two vectors buffered
        apply_reset(2);
        add_vec(64'hD1, 1'b1, 0);
        add_vec(64'hD2, 1'b0, 0);
        add_vec(64'hD3, 1'b1, 0);
        run_plan(3);
        apply_reset(DN + 2);
        add_vec(64'hE1E2E3E4E5E6E7E8, 1'b1, 0);
        run_plan(0);

        // random traffic
        apply_reset(2);
        for (int i = 0; i < 150; i++) begin
            add_vec({$urandom, $urandom},
                    (i == 149) || ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        run_plan(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
